branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the beq/bne comparator. It resolves eight branch conditions, including signed and unsigned compares against zero and between operands, in one registered pipeline stage with stall and flush control. It also detects mispredicts against the front-end prediction and keeps a table of 2-bit saturating predictors. It sits at the ID/EX boundary of the dynamic pipeline and drives the PC-redirect path.

Parameters:
DATA_W, 32, operand width in bits
BHT_DEPTH, 64, number of predictor entries; must be a power of 2, at least 2
PC_W, 32, PC and target width
FALL_OFS, 4, fall-through offset added to the branch PC on a not-taken redirect

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  branch op present this cycle
stall  in  1  hold the stage; no capture and no table update
flush  in  1  kill the stage contents and the incoming op
num1  in  DATA_W  rs operand, forwarded
num2  in  DATA_W  rt operand, forwarded
cmp_mode  in  3  condition code, encodings from bru_pkg
pc  in  PC_W  branch instruction PC
target  in  PC_W  taken target
pred_taken  in  1  front-end prediction for this op
lookup_pc  in  PC_W  fetch-side predictor query
lookup_taken  out  1  MSB of the indexed counter; combinational
out_valid  out  1  resolved result is valid
is_branch  out  1  condition true (taken)
mispredict  out  1  out_valid and (is_branch != registered pred_taken)
redirect_pc  out  PC_W  target if taken, otherwise pc+FALL_OFS
branch_cnt  out  32  resolved-branch count (optional feature)
mispred_cnt  out  32  mispredict count (optional feature)

Behaviour:
- cmp_mode encodings: 000 EQ (num1==num2); 001 NE; 010 LEZ (signed num1<=0); 011 GTZ (signed num1>0); 100 LTZ; 101 GEZ; 110 LT (signed num1<num2); 111 LTU (unsigned num1<num2). Zero compares ignore num2.
- Capture condition: in_valid & !stall & !flush. On capture, next edge registers taken, pred_taken, pc, target and sets out_valid=1. Latency is 1 cycle.
- No capture and no stall: out_valid clears at the next edge.
- stall=1 and flush=0: every register holds and out_valid holds its value. No table update occurs.
- flush=1: out_valid clears at the next edge regardless of stall and in_valid. No table update occurs. flush has priority over stall.
- is_branch, mispredict and redirect_pc are derived from the registered state. They read 0 when out_valid=0.
- redirect_pc addition wraps modulo 2^PC_W.
- Predictor table: BHT_DEPTH entries of 2-bit counters, indexed by pc[log2(BHT_DEPTH)+1:2].
  - Reset value of every entry is 01 (weakly not-taken).
  - Update happens on the capture edge using the computed taken value. Taken increments, saturating at 11. Not-taken decrements, saturating at 00.
  - lookup_taken = counter[idx(lookup_pc)][1]. If the lookup index equals the update index in the same cycle, the pre-update value is returned (read-before-write).
- Reset (asynchronous, any cycle, including mid-stall): out_valid, is_branch, mispredict and redirect_pc go to 0, the table returns to 01 and the counters go to 0. The first capture is allowed on the first edge after rst_n rises.

Optional Feature:
BRU_PERF_CNT_EN
- Defined: branch_cnt increments on each capture. mispred_cnt increments on each cycle where a newly valid result mispredicts, i.e. once per resolved branch, not per stalled cycle. Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- bru_pkg holds:
  - the cmp_mode localparams (CMP_EQ through CMP_LTU)
  - the counter state constants SNT=00, WNT=01, WT=10, ST=11
  - an index-width function clog2
- Sub-module bru_bht holds the counter array, the combinational read port and the saturating update port. The top level holds compare logic, the pipeline register, redirect and counters.

Test Plan:
- Reset then EQ with num1=num2=0x5 and pred_taken=0 -> next cycle out_valid=1, is_branch=1, mispredict=1, redirect_pc=target.
- All 8 modes with num1=0xFFFFFFFF, num2=0x1 -> LT=1, LTU=0, LTZ=1, GEZ=0, LEZ=1, GTZ=0, NE=1, EQ=0.
- pc=0x100 taken three times in a row -> lookup_taken(0x100) goes 0,1,1. Counter reads 10 then 11, saturated. One not-taken update -> counter 10, lookup_taken still 1.
- Capture, then stall for 3 cycles, then flush -> outputs held for 3 cycles, out_valid=0 after the flush edge, and no further table change.
- Stall and flush asserted in the same cycle with in_valid=1 -> no capture, out_valid=0, table unchanged. Reset asserted mid-stall -> all outputs 0 immediately.
- With BRU_PERF_CNT_EN: 5 branches with 2 mispredicts, one of them stalled for 2 cycles -> branch_cnt=5, mispred_cnt=2.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, predictor states, index width helper.
package bru_pkg;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LEZ = 3'b010;
    localparam logic [2:0] CMP_GTZ = 3'b011;
    localparam logic [2:0] CMP_LTZ = 3'b100;
    localparam logic [2:0] CMP_GEZ = 3'b101;
    localparam logic [2:0] CMP_LT  = 3'b110;
    localparam logic [2:0] CMP_LTU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width = width + 1;
        return width;
    endfunction

endpackage

// File: rtl/bru_bht.sv
// Table of 2-bit saturating branch predictors with one combinational read port and one update port.
module bru_bht
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_t ctrs [DEPTH];
    ctr_t wr_next;

    // Reads the registered array, so a same-cycle update is not visible until the next cycle.
    assign rd_taken = ctrs[rd_idx][1];

    always_comb begin
        wr_next = ctrs[wr_idx];
        if (wr_taken) begin
            if (ctrs[wr_idx] != ST) wr_next = ctr_t'(ctrs[wr_idx] + 2'd1);
        end else begin
            if (ctrs[wr_idx] != SNT) wr_next = ctr_t'(ctrs[wr_idx] - 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) ctrs[i] <= WNT;
        end else if (wr_en) begin
            ctrs[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID/EX branch resolution stage: condition compare, mispredict detection, redirect PC and predictor training.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned FALL_OFS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    input  logic [2:0]        cmp_mode,
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   target,
    input  logic              pred_taken,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              lookup_taken,
    output logic              out_valid,
    output logic              is_branch,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispred_cnt
);

    localparam int unsigned IDX_W = clog2(BHT_DEPTH);

    logic            taken;
    logic            capture;
    logic            num1_neg;
    logic            num1_zero;
    logic            valid_r;
    logic            taken_r;
    logic            pred_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] target_r;
    logic            unused_pc_bits;

    assign capture   = in_valid & ~stall & ~flush;
    assign num1_neg  = num1[DATA_W-1];
    assign num1_zero = (num1 == '0);

    always_comb begin
        taken = 1'b0;
        case (cmp_mode)
            CMP_EQ:  taken = (num1 == num2);
            CMP_NE:  taken = (num1 != num2);
            CMP_LEZ: taken = num1_neg | num1_zero;
            CMP_GTZ: taken = ~num1_neg & ~num1_zero;
            CMP_LTZ: taken = num1_neg;
            CMP_GEZ: taken = ~num1_neg;
            CMP_LT:  taken = ($signed(num1) < $signed(num2));
            CMP_LTU: taken = (num1 < num2);
            default: taken = 1'b0;
        endcase
    end

    // Flush wins over stall; a stall freezes the whole stage including out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            taken_r  <= 1'b0;
            pred_r   <= 1'b0;
            pc_r     <= '0;
            target_r <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (!stall) begin
            valid_r <= in_valid;
            if (in_valid) begin
                taken_r  <= taken;
                pred_r   <= pred_taken;
                pc_r     <= pc;
                target_r <= target;
            end
        end
    end

    assign out_valid   = valid_r;
    assign is_branch   = valid_r & taken_r;
    assign mispredict  = valid_r & (taken_r != pred_r);
    assign redirect_pc = !valid_r ? '0 : (taken_r ? target_r : pc_r + PC_W'(FALL_OFS));

    bru_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lookup_pc[IDX_W+1:2]),
        .rd_taken (lookup_taken),
        .wr_en    (capture),
        .wr_idx   (pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign unused_pc_bits = ^{pc, lookup_pc};

`ifdef BRU_PERF_CNT_EN
    // Counted at capture so a stalled result is never counted twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (capture) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (taken != pred_taken) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a behavioural model of conditions, stage and predictors.
module tb_branch_resolve_unit;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BHT_DEPTH = 64;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned FALL_OFS  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] num1 = '0;
    logic [31:0] num2 = '0;
    logic [2:0]  cmp_mode = '0;
    logic [31:0] pc = '0;
    logic [31:0] target = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        lookup_taken;
    logic        out_valid;
    logic        is_branch;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DATA_W    (DATA_W),
        .BHT_DEPTH (BHT_DEPTH),
        .PC_W      (PC_W),
        .FALL_OFS  (FALL_OFS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .num1         (num1),
        .num2         (num2),
        .cmp_mode     (cmp_mode),
        .pc           (pc),
        .target       (target),
        .pred_taken   (pred_taken),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken),
        .out_valid    (out_valid),
        .is_branch    (is_branch),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    // Behavioural model state
    int          m_ctr [BHT_DEPTH];
    bit          m_valid, m_taken, m_pred;
    logic [31:0] m_pc, m_target;
    int unsigned m_bcnt, m_mcnt;

    function automatic bit ref_cond(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (mode)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            3'd6: return sa < sb;
            default: return a < b;
        endcase
    endfunction

    function automatic int idx(input logic [31:0] p);
        return int'((p >> 2) % BHT_DEPTH);
    endfunction

    function automatic logic [2:0] exp_flags();
        return {m_valid, m_valid & m_taken, m_valid & (m_taken != m_pred)};
    endfunction

    function automatic logic [31:0] exp_redirect();
        if (!m_valid) return 32'h0;
        return m_taken ? m_target : m_pc + FALL_OFS;
    endfunction

    function automatic bit exp_lookup(input logic [31:0] p);
        return m_ctr[idx(p)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(BHT_DEPTH); i++) m_ctr[i] = 1;
        m_valid = 0; m_taken = 0; m_pred = 0; m_pc = '0; m_target = '0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    task automatic drive_op(input bit v, input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p, input logic [31:0] t, input bit pr);
        in_valid = v; cmp_mode = mode; num1 = a; num2 = b; pc = p; target = t; pred_taken = pr;
    endtask

    // Advance the model by one clock edge from the current inputs, then step the DUT.
    task automatic tick();
        bit t;
        int i;
        t = ref_cond(cmp_mode, num1, num2);
        if (flush) begin
            m_valid = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            if (in_valid) begin
                m_taken = t; m_pred = pred_taken; m_pc = pc; m_target = target;
                i = idx(pc);
                if (t) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else   m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                m_bcnt++;
                if (t != pred_taken) m_mcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, is_branch, mispredict} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b expected 000", {out_valid, is_branch, mispredict});
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            fails++; $display("FAIL reset_redirect: got %h expected 0", redirect_pc);
        end
        checks++;
        if ({branch_cnt, mispred_cnt} !== 64'h0) begin
            fails++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            lookup_pc = 32'h40 * k + 32'h4;
            #1;
            checks++;
            if (lookup_taken !== 1'b0) begin
                fails++; $display("FAIL reset_lookup pc=%h: got %b expected 0", lookup_pc, lookup_taken);
            end
        end
        rst_n = 1;
    endtask

    task automatic test_eq_first();
        drive_op(1, 3'd0, 32'h5, 32'h5, 32'h44, 32'h800, 0);
        tick();
        in_valid = 0;
        checks++;
        if ({out_valid, is_branch, mispredict} !== 3'b111) begin
            fails++; $display("FAIL eq_first_flags: got %b expected 111", {out_valid, is_branch, mispredict});
        end
        checks++;
        if (redirect_pc !== 32'h800) begin
            fails++; $display("FAIL eq_first_redirect: got %h expected 00000800", redirect_pc);
        end
        tick();
        checks++;
        if ({out_valid, is_branch, mispredict, redirect_pc} !== {exp_flags(), exp_redirect()}) begin
            fails++; $display("FAIL eq_first_drain: got %b/%h expected %b/%h",
                              {out_valid, is_branch, mispredict}, redirect_pc, exp_flags(), exp_redirect());
        end
    endtask

    task automatic test_all_modes();
        logic [7:0] want;
        want = 8'b0101_0110; // bit k = expected result of mode k: EQ0 NE1 LEZ1 GTZ0 LTZ1 GEZ0 LT1 LTU0
        for (int m = 0; m < 8; m++) begin
            drive_op(1, 3'(m), 32'hFFFF_FFFF, 32'h1, 32'h220 + 32'(4 * m), 32'h1000 + 32'(m), 1);
            tick();
            checks++;
            if (is_branch !== want[m] || out_valid !== 1'b1) begin
                fails++; $display("FAIL mode_%0d: got valid=%b taken=%b expected valid=1 taken=%b", m, out_valid, is_branch, want[m]);
            end
            checks++;
            if (redirect_pc !== exp_redirect()) begin
                fails++; $display("FAIL mode_%0d_redirect: got %h expected %h", m, redirect_pc, exp_redirect());
            end
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_saturation();
        bit seq_taken [5] = '{1, 1, 1, 0, 0};
        bit seq_pre   [5] = '{0, 1, 1, 1, 1};
        bit seq_post  [5] = '{1, 1, 1, 1, 0};
        lookup_pc = 32'h100;
        for (int k = 0; k < 5; k++) begin
            drive_op(1, 3'd0, 32'h7, seq_taken[k] ? 32'h7 : 32'h8, 32'h100, 32'h180, 1);
            #1;
            checks++;
            if (lookup_taken !== seq_pre[k] || lookup_taken !== exp_lookup(32'h100)) begin
                fails++; $display("FAIL sat_rbw_%0d: got %b expected %b", k, lookup_taken, seq_pre[k]);
            end
            tick();
            checks++;
            if (lookup_taken !== seq_post[k] || lookup_taken !== exp_lookup(32'h100)) begin
                fails++; $display("FAIL sat_post_%0d: got %b expected %b", k, lookup_taken, seq_post[k]);
            end
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_stall_flush();
        lookup_pc = 32'h300;
        drive_op(1, 3'd1, 32'h1, 32'h2, 32'h300, 32'h3F0, 1);
        tick();
        drive_op(1, 3'd0, 32'h1, 32'h2, 32'h300, 32'h555, 0);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out_valid, is_branch, mispredict, redirect_pc} !== {3'b110, 32'h3F0}) begin
                fails++; $display("FAIL stall_hold_%0d: got %b/%h expected 110/000003f0",
                                  k, {out_valid, is_branch, mispredict}, redirect_pc);
            end
        end
        flush = 1;
        tick();
        flush = 0; stall = 0; in_valid = 0;
        checks++;
        if ({out_valid, is_branch, mispredict, redirect_pc} !== {3'b000, 32'h0}) begin
            fails++; $display("FAIL flush_clear: got %b/%h expected 000/0", {out_valid, is_branch, mispredict}, redirect_pc);
        end
        checks++;
        if (lookup_taken !== 1'b1 || lookup_taken !== exp_lookup(32'h300)) begin
            fails++; $display("FAIL stall_table: got %b expected 1", lookup_taken);
        end
    endtask

    task automatic test_stall_flush_same();
        drive_op(1, 3'd0, 32'h9, 32'h9, 32'h304, 32'h10, 0);
        tick();
        drive_op(1, 3'd0, 32'h1, 32'h2, 32'h300, 32'h20, 1);
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0; in_valid = 0;
        lookup_pc = 32'h300;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {out_valid, is_branch, mispredict} !== exp_flags()) begin
            fails++; $display("FAIL stall_flush_same_valid: got %b expected 000", {out_valid, is_branch, mispredict});
        end
        checks++;
        if (lookup_taken !== 1'b1 || lookup_taken !== exp_lookup(32'h300)) begin
            fails++; $display("FAIL stall_flush_same_table: got %b expected 1", lookup_taken);
        end
    endtask

    task automatic test_reset_mid_stall();
        lookup_pc = 32'h300;
        drive_op(1, 3'd6, 32'hFFFF_FFF0, 32'h3, 32'h300, 32'h7000, 0);
        tick();
        stall = 1;
        tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({out_valid, is_branch, mispredict, redirect_pc} !== {3'b000, 32'h0}) begin
            fails++; $display("FAIL reset_mid_stall_out: got %b/%h expected 000/0", {out_valid, is_branch, mispredict}, redirect_pc);
        end
        checks++;
        if (lookup_taken !== 1'b0 || {branch_cnt, mispred_cnt} !== 64'h0) begin
            fails++; $display("FAIL reset_mid_stall_state: got lookup=%b cnt=%0d/%0d expected 0 0/0", lookup_taken, branch_cnt, mispred_cnt);
        end
        @(posedge clk);
        #1;
        stall = 0;
        rst_n = 1;
        drive_op(1, 3'd7, 32'h1, 32'h2, 32'h400, 32'h4400, 0);
        tick();
        in_valid = 0;
        checks++;
        if ({out_valid, is_branch, mispredict, redirect_pc} !== {3'b111, 32'h4400}) begin
            fails++; $display("FAIL first_after_reset: got %b/%h expected 111/00004400", {out_valid, is_branch, mispredict}, redirect_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] pcs [8];
        int r;
        for (int k = 0; k < 8; k++) pcs[k] = 32'h1000 + 32'(k * 4) + ((k >= 4) ? 32'h100 : 32'h0);
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 3);
            num1 = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'($urandom_range(0, 5)) : $urandom;
            num2 = $urandom_range(0, 1) ? num1 : $urandom;
            cmp_mode   = 3'($urandom_range(0, 7));
            in_valid   = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            pred_taken = 1'($urandom_range(0, 1));
            pc         = pcs[$urandom_range(0, 7)];
            target     = $urandom;
            if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FFFC;
            lookup_pc  = $urandom_range(0, 1) ? pc : pcs[$urandom_range(0, 7)];
            #1;
            checks++;
            if (lookup_taken !== exp_lookup(lookup_pc)) begin
                fails++; $display("FAIL rand_lookup_%0d: got %b expected %b", n, lookup_taken, exp_lookup(lookup_pc));
            end
            tick();
            checks++;
            if ({out_valid, is_branch, mispredict, redirect_pc} !== {exp_flags(), exp_redirect()}) begin
                fails++; $display("FAIL rand_out_%0d: got %b/%h expected %b/%h",
                                  n, {out_valid, is_branch, mispredict}, redirect_pc, exp_flags(), exp_redirect());
            end
`ifdef BRU_PERF_CNT_EN
            checks++;
            if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
                fails++; $display("FAIL rand_cnt_%0d: got %0d/%0d expected %0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
            end
`endif
        end
        in_valid = 0; stall = 0; flush = 0;
        tick();
    endtask

    task automatic test_perf_cnt();
        bit preds [5] = '{1, 0, 0, 1, 1};
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            drive_op(1, 3'd0, 32'h3, 32'h3, 32'h2000 + 32'(4 * k), 32'h9000, preds[k]);
            tick();
            if (k == 2) begin
                stall = 1;
                repeat (2) tick();
                stall = 0;
            end
        end
        in_valid = 0;
        tick();
`ifdef BRU_PERF_CNT_EN
        checks++;
        if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd2) begin
            fails++; $display("FAIL perf_cnt: got %0d/%0d expected 5/2", branch_cnt, mispred_cnt);
        end
`else
        checks++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            fails++; $display("FAIL perf_cnt_tied: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_eq_first();
        test_all_modes();
        test_saturation();
        test_stall_flush();
        test_stall_flush_same();
        test_reset_mid_stall();
        test_random();
        test_perf_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
